// File: rtl/tp_entrada_nota_pkg.sv
// Shared definitions for the note entry path: debounce states and note codes.
// Also reused by the note classifier.
package tp_entrada_nota_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

  localparam logic [2:0] NOTA_X   = 3'b000;
  localparam logic [2:0] NOTA_DO  = 3'b001;
  localparam logic [2:0] NOTA_RE  = 3'b010;
  localparam logic [2:0] NOTA_MI  = 3'b011;
  localparam logic [2:0] NOTA_FA  = 3'b100;
  localparam logic [2:0] NOTA_SOL = 3'b101;
  localparam logic [2:0] NOTA_LA  = 3'b110;
  localparam logic [2:0] NOTA_SI  = 3'b111;

  localparam int LONGPRESS_MULT = 8;

  function automatic logic [2:0] sat_inc3(
    input logic [2:0] v,
    input logic [2:0] max
  );
    return (v >= max) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/tp_entrada_nota_sincronizador.sv
// tp_sincronizador: STAGES-deep flop chain bringing W asynchronous bits
// into the clk domain.
module tp_sincronizador #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/tp_entrada_nota.sv
// Note entry stage: sync + debounce of OK button and note/tone switches.
// Optional long-press clear enabled by TP_ENTRADA_LONGPRESS_CLEAR_EN.
module tp_entrada_nota
  import tp_entrada_nota_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int MAX_NOTES       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ok_raw,
  input  logic       sw_tom_raw,
  input  logic [2:0] sw_nota_raw,
  input  logic       fim,
  output logic       ok,
  output logic       tom,
  output logic [2:0] nota,
  output logic [2:0] note_cnt,
  output logic       dropped
`ifdef TP_ENTRADA_LONGPRESS_CLEAR_EN
  ,
  output logic       clr
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_CONF = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] NMAX = 3'(MAX_NOTES);

  logic       btn_s;
  logic       tom_s;
  logic [2:0] nota_s;

  tp_sincronizador #(
    .W      (5),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({btn_ok_raw, sw_tom_raw, sw_nota_raw}),
    .q     ({btn_s, tom_s, nota_s})
  );

  deb_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          confirm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The current cycle counts toward the stable run, so compare cnt+1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    confirm   = 1'b0;
    cnt_inc   = (cnt == CNT_TERM) ? cnt : cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_inc >= CNT_CONF) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          confirm   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt_inc >= CNT_CONF) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef TP_ENTRADA_LONGPRESS_CLEAR_EN
  localparam int LP_N = LONGPRESS_MULT * DEBOUNCE_CYCLES;
  localparam int LW   = $clog2(LP_N + 1);
  localparam logic [LW-1:0] LP_TERM = LW'(LP_N);
  localparam logic [LW-1:0] LP_FIRE = LW'(LP_N - 1);

  logic [LW-1:0] lp_cnt;
  logic          stay_held;
  logic          lp_fire;

  assign stay_held = (state == HELD) && (state_nxt == HELD);
  assign lp_fire   = stay_held && (lp_cnt == LP_FIRE);

  // Saturates at LP_TERM so the clear fires only once per hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lp_cnt <= '0;
    end else if (stay_held) begin
      if (lp_cnt != LP_TERM) lp_cnt <= lp_cnt + 1'b1;
    end else begin
      lp_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr <= 1'b0;
    end else begin
      clr <= lp_fire;
    end
  end
`else
  logic lp_fire;
  assign lp_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ok       <= 1'b0;
      tom      <= 1'b0;
      nota     <= NOTA_X;
      note_cnt <= '0;
      dropped  <= 1'b0;
    end else begin
      ok <= confirm && !fim;
      if (confirm) begin
        if (!fim) begin
          tom      <= tom_s;
          nota     <= nota_s;
          note_cnt <= sat_inc3(note_cnt, NMAX);
        end else begin
          dropped <= 1'b1;
        end
      end
      if (lp_fire) note_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_tp_entrada_nota.sv
// Scoreboard bench for tp_entrada_nota (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Expected ok pulses are queued by stimulus and checked by a monitor.
module tb_tp_entrada_nota;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_ok_raw = 1'b0;
  logic       sw_tom_raw = 1'b0;
  logic [2:0] sw_nota_raw = 3'b000;
  logic       fim = 1'b0;
  logic       ok;
  logic       tom;
  logic [2:0] nota;
  logic [2:0] note_cnt;
  logic       dropped;
`ifdef TP_ENTRADA_LONGPRESS_CLEAR_EN
  logic       clr;
`endif

  tp_entrada_nota #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .MAX_NOTES       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_ok_raw  (btn_ok_raw),
    .sw_tom_raw  (sw_tom_raw),
    .sw_nota_raw (sw_nota_raw),
    .fim         (fim),
    .ok          (ok),
    .tom         (tom),
    .nota        (nota),
    .note_cnt    (note_cnt),
    .dropped     (dropped)
`ifdef TP_ENTRADA_LONGPRESS_CLEAR_EN
    ,
    .clr         (clr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] nota;
    logic       tom;
    logic [2:0] cnt;
  } exp_t;

  exp_t q_ok[$];
  int   q_clr[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_cnt = 0;
  exp_t mon_e;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && ok) begin
      if (q_ok.size() == 0) begin
        chk("unexpected_ok", 1, 0);
      end else begin
        mon_e = q_ok.pop_front();
        chk("ok_cycle", cyc, mon_e.cyc);
        chk("ok_nota", int'(nota), int'(mon_e.nota));
        chk("ok_tom", int'(tom), int'(mon_e.tom));
        chk("ok_note_cnt", int'(note_cnt), int'(mon_e.cnt));
      end
    end
  end

`ifdef TP_ENTRADA_LONGPRESS_CLEAR_EN
  always @(negedge clk) begin
    if (reset && clr) begin
      if (q_clr.size() == 0) chk("unexpected_clr", 1, 0);
      else chk("clr_cycle", cyc, q_clr.pop_front());
    end
  end
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ok(input logic [2:0] n, input logic t, input int at);
    exp_t e;
    if (model_cnt < 4) model_cnt++;
    e.cyc  = at;
    e.nota = n;
    e.tom  = t;
    e.cnt  = 3'(model_cnt);
    q_ok.push_back(e);
  endtask

  task automatic press(input logic [2:0] n, input logic t, input int hi,
                       input bit accept);
    sw_nota_raw = n;
    sw_tom_raw  = t;
    tick(1);
    btn_ok_raw = 1'b1;
    if (accept) expect_ok(n, t, cyc + 6);
    tick(hi);
    btn_ok_raw = 1'b0;
    tick(12);
  endtask

  task automatic bounce_press(input logic [2:0] n, input logic t);
    sw_nota_raw = n;
    sw_tom_raw  = t;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      btn_ok_raw = (i % 2 == 0);
      tick(1);
    end
    btn_ok_raw = 1'b1;
    expect_ok(n, t, cyc + 6);
    tick(6);
    btn_ok_raw = 1'b0;
    tick(12);
  endtask

  initial begin
    tick(3);
    chk("rst_ok", int'(ok), 0);
    chk("rst_tom", int'(tom), 0);
    chk("rst_nota", int'(nota), 0);
    chk("rst_note_cnt", int'(note_cnt), 0);
    chk("rst_dropped", int'(dropped), 0);
    reset = 1'b1;
    tick(3);

    press(3'b110, 1'b0, 10, 1'b1);
    bounce_press(3'b011, 1'b1);
    press(3'b001, 1'b0, 8, 1'b1);
    press(3'b000, 1'b1, 8, 1'b1);
    press(3'b111, 1'b0, 8, 1'b1);
    press(3'b101, 1'b1, 8, 1'b1);
    chk("dropped_before_fim", int'(dropped), 0);

    fim = 1'b1;
    press(3'b010, 1'b0, 8, 1'b0);
    fim = 1'b0;
    chk("fim_nota_held", int'(nota), 5);
    chk("fim_tom_held", int'(tom), 1);
    chk("fim_note_cnt_held", int'(note_cnt), 4);
    chk("fim_dropped", int'(dropped), 1);

    sw_nota_raw = 3'b010;
    tick(1);
    btn_ok_raw = 1'b1;
    tick(5);
    reset = 1'b0;
    #1;
    chk("arst_ok", int'(ok), 0);
    chk("arst_tom", int'(tom), 0);
    chk("arst_nota", int'(nota), 0);
    chk("arst_note_cnt", int'(note_cnt), 0);
    chk("arst_dropped", int'(dropped), 0);
    model_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(2);
    btn_ok_raw = 1'b0;
    tick(15);
    chk("post_arst_note_cnt", int'(note_cnt), 0);

    press(3'b100, 1'b1, 10, 1'b1);

`ifdef TP_ENTRADA_LONGPRESS_CLEAR_EN
    sw_nota_raw = 3'b011;
    sw_tom_raw  = 1'b0;
    tick(1);
    btn_ok_raw = 1'b1;
    expect_ok(3'b011, 1'b0, cyc + 6);
    q_clr.push_back(cyc + 38);
    tick(50);
    btn_ok_raw = 1'b0;
    model_cnt = 0;
    tick(12);
    chk("lp_note_cnt", int'(note_cnt), 0);
`endif

    tick(20);
    chk("ok_queue_drained", q_ok.size(), 0);
    chk("clr_queue_drained", q_clr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tp_entrada_nota.md
Name: tp_entrada_nota

Overview:
Input-conditioning stage directly upstream of the note classifier FSM. Synchronizes and debounces the raw OK push-button and the note/tone switches. On each confirmed press it emits one clean single-cycle `ok` pulse, together with a stable `nota`/`tom` sample, which feeds the classifier's `ok`, `nota` and `tom` inputs. It also counts accepted notes and drops presses while the classifier reports `fim`.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to accept a press or a release
SYNC_STAGES, 2, flip-flop depth of the input synchronizer (minimum 2)
MAX_NOTES, 4, saturation value of note_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
btn_ok_raw  input  1  raw OK push-button, bouncing, asynchronous
sw_tom_raw  input  1  raw tone switch, asynchronous
sw_nota_raw  input  3  raw note switches, asynchronous, 000 = no note
fim  input  1  classifier finished flag; presses are dropped while high
ok  output  1  single-cycle accepted-press pulse to classifier
tom  output  1  registered tone sample, stable between pulses
nota  output  3  registered note sample, stable between pulses
note_cnt  output  3  accepted notes since reset, saturating at MAX_NOTES
dropped  output  1  sticky flag: a press was confirmed while fim=1

Behaviour:
- Reset (reset=0, asynchronous):
  - ok=0, tom=0, nota=000, note_cnt=0, dropped=0.
  - Synchronizer flops 0; debounce counter 0; FSM in IDLE.
- Synchronizer: btn_ok_raw, sw_tom_raw and sw_nota_raw each pass through SYNC_STAGES flops. All downstream logic uses only the synchronized copies, called btn_s, tom_s, nota_s.
- Debounce FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: btn_s=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: btn_s=1 increments the counter. When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still 1 -> HELD and the press is confirmed. btn_s=0 at any point -> IDLE, counter cleared.
  - HELD: btn_s=0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: btn_s=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE. btn_s=1 -> HELD.
- Confirmed press, registered on the PRESS_WAIT->HELD edge:
  - If fim=0: ok=1 for exactly one cycle. tom<=tom_s and nota<=nota_s on the same edge. note_cnt increments, saturating at MAX_NOTES.
  - If fim=1: ok stays 0; tom, nota and note_cnt are unchanged; dropped<=1.
- Pulse count: at most one ok per press/release cycle, however long the button is held.
- Latency: a clean input edge produces ok after SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- nota=000 is forwarded unchanged. Rejecting it is the classifier's decision, not this block's.
- dropped clears only on reset.
- Counter width: clog2(DEBOUNCE_CYCLES+1). The counter never wraps; it holds at the terminal value.
- Reset asserted mid-debounce aborts the press: no ok is produced.

Optional Feature:
Macro TP_ENTRADA_LONGPRESS_CLEAR_EN.
- With the macro: an extra output port `clr` (1 bit) is added.
  - While in HELD, a second counter runs. After 8*DEBOUNCE_CYCLES cycles held, clr=1 for one cycle and note_cnt<=0.
  - clr fires only once per hold and is intended for the classifier's synchronous reset.
  - The long-press counter clears on leaving HELD.
- Without the macro: no clr port and no long-press counter; a long hold behaves exactly like a short press.

Decomposition:
- Shared package: debounce state encoding and the note code constants (nota_x=000 … si=111), reused by the classifier.
- One natural sub-module: tp_sincronizador, a parameterized SYNC_STAGES-deep synchronizer of configurable width, instantiated once for the 5 input bits.

Test Plan:
- Test configuration for all scenarios: DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
- Clean press: sw_nota_raw=110, sw_tom_raw=0, btn high 10 cycles -> exactly one ok pulse 6 cycles after the edge; nota=110, tom=0, note_cnt=1.
- Bounce: btn toggles 1,0,1,0 on alternate cycles, then holds high 6 cycles -> a single ok, emitted only after the stable run.
- Saturation: 6 clean presses with fim=0 -> 6 ok pulses; note_cnt reads 1,2,3,4,4,4.
- fim gating: fim=1 during a confirmed press -> no ok, nota unchanged, dropped=1, note_cnt unchanged.
- Async reset mid-PRESS_WAIT: reset=0 for 1 cycle at debounce count 2 -> all outputs immediately 0; no ok follows, even if btn stays high for fewer than 4 further cycles.
- With TP_ENTRADA_LONGPRESS_CLEAR_EN: btn held 50 cycles -> one ok, then one clr pulse 32 cycles after entering HELD; note_cnt=0.
